// File: rtl/limbic_pkg.sv
// Shared types for the limbic input conditioner: FSM states, channel tags and
// the 9-bit to 8-bit saturation helper.
package limbic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DECAY = 2'd2,
        EMIT  = 2'd3
    } state_t;

    localparam logic CH_FEAR  = 1'b0;
    localparam logic CH_DOUBT = 1'b1;

    typedef struct packed {
        logic       sat;
        logic [7:0] val;
    } sat8_t;

    function automatic sat8_t sat8(input logic [8:0] v);
        sat8_t r;
        r.sat = v[8];
        r.val = v[8] ? 8'hFF : v[7:0];
        return r;
    endfunction

endpackage

// File: rtl/leaky_level_unit.sv
// Combinational leaky integrator step: level loses level>>DECAY_SHIFT, gains
// the window mean, and clamps at 255 with a flag when the 9-bit sum exceeds it.
module leaky_level_unit
    import limbic_pkg::*;
#(
    parameter int DECAY_SHIFT = 2
) (
    input  logic [7:0] level,
    input  logic [7:0] mean,
    output logic [7:0] nxt,
    output logic       sat
);

    logic [7:0] leak;
    logic [8:0] sum9;
    sat8_t      clamped;

    assign leak    = level >> DECAY_SHIFT;
    // level - leak never underflows, so the 9-bit sum is exact.
    assign sum9    = {1'b0, level} - {1'b0, leak} + {1'b0, mean};
    assign clamped = sat8(sum9);
    assign nxt     = clamped.val;
    assign sat     = clamped.sat;

endmodule

// File: rtl/limbic_input_conditioner.sv
// Windowed averaging front end for the fear/doubt inputs of the cognitive
// accelerator, with a leaky saturating level per channel.
//
//   state | meaning
//   IDLE  | waiting for first sample of a window, s_ready high
//   ACCUM | collecting samples until WIN_LEN have been accepted
//   DECAY | apply leak + mean to both levels, latch saturation
//   EMIT  | publish new levels, pulse out_valid, clear window
module limbic_input_conditioner
    import limbic_pkg::*;
#(
    parameter int WIN_LEN     = 8,
    parameter int DECAY_SHIFT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_chan,
    input  logic [7:0]  s_data,
    output logic [7:0]  fear,
    output logic [7:0]  doubt,
    output logic        out_valid,
    output logic        overflow,
    output logic [15:0] window_count
);

    localparam int LOG2_WIN = $clog2(WIN_LEN);
    localparam int ACC_W    = 8 + LOG2_WIN;
    localparam int CNT_W    = LOG2_WIN + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_LEN - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc_f, acc_d;
    logic [7:0]       nxt_f, nxt_d;
    logic [7:0]       mean_f, mean_d;
    logic [7:0]       lu_f, lu_d;
    logic             sat_f, sat_d;
    logic             accept;

    assign accept = s_valid && s_ready;
    assign mean_f = 8'(acc_f >> LOG2_WIN);
    assign mean_d = 8'(acc_d >> LOG2_WIN);

    leaky_level_unit #(.DECAY_SHIFT(DECAY_SHIFT)) u_fear_level (
        .level (fear),
        .mean  (mean_f),
        .nxt   (lu_f),
        .sat   (sat_f)
    );

    leaky_level_unit #(.DECAY_SHIFT(DECAY_SHIFT)) u_doubt_level (
        .level (doubt),
        .mean  (mean_d),
        .nxt   (lu_d),
        .sat   (sat_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            s_ready      <= 1'b0;
            cnt          <= '0;
            acc_f        <= '0;
            acc_d        <= '0;
            nxt_f        <= 8'd0;
            nxt_d        <= 8'd0;
            fear         <= 8'd0;
            doubt        <= 8'd0;
            out_valid    <= 1'b0;
            overflow     <= 1'b0;
            window_count <= 16'd0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (s_chan == CH_FEAR) acc_f <= acc_f + ACC_W'(s_data);
                        else                   acc_d <= acc_d + ACC_W'(s_data);
                        // s_ready drops with the last sample so DECAY/EMIT back-pressure.
                        if (cnt == CNT_LAST) begin
                            state   <= DECAY;
                            s_ready <= 1'b0;
                        end else begin
                            cnt     <= cnt + 1'b1;
                            state   <= ACCUM;
                            s_ready <= 1'b1;
                        end
                    end else begin
                        s_ready <= 1'b1;
                    end
                end
                DECAY: begin
                    nxt_f <= lu_f;
                    nxt_d <= lu_d;
                    if (sat_f || sat_d) overflow <= 1'b1;
                    state <= EMIT;
                end
                EMIT: begin
                    fear         <= nxt_f;
                    doubt        <= nxt_d;
                    out_valid    <= 1'b1;
                    window_count <= window_count + 16'd1;
                    acc_f        <= '0;
                    acc_d        <= '0;
                    cnt          <= '0;
                    s_ready      <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_limbic_input_conditioner.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a window/level arithmetic model every cycle.
module tb_limbic_input_conditioner;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        s_chan = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic [7:0]  fear, doubt;
    logic        out_valid, overflow;
    logic [15:0] window_count;

    int n_cmp = 0;
    int n_err = 0;

    limbic_input_conditioner #(.WIN_LEN(8), .DECAY_SHIFT(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_chan       (s_chan),
        .s_data       (s_data),
        .fear         (fear),
        .doubt        (doubt),
        .out_valid    (out_valid),
        .overflow     (overflow),
        .window_count (window_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: list of window sums, levels, pending result and dead-cycle count.
    int m_fear = 0, m_doubt = 0, m_wc = 0;
    int p_fear = 0, p_doubt = 0;
    bit m_ovf = 0, p_sat = 0, m_pulse = 0, rdy_ok = 0, armed = 0;
    int sum_f = 0, sum_d = 0, n_smp = 0, due = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_fear = 0; m_doubt = 0; m_wc = 0; m_ovf = 0; m_pulse = 0;
            sum_f = 0; sum_d = 0; n_smp = 0; due = 0; rdy_ok = 0;
            if (clk) armed = 1;
        end else begin
            armed = 1;
            m_pulse = 0;
            if (due == 2) begin
                due = 1;
                if (p_sat) m_ovf = 1;
            end else if (due == 1) begin
                due = 0;
                m_fear = p_fear;
                m_doubt = p_doubt;
                m_wc = (m_wc + 1) % 65536;
                m_pulse = 1;
            end
            if (s_valid && s_ready) begin
                if (s_chan) sum_d += s_data; else sum_f += s_data;
                n_smp++;
                if (n_smp == 8) begin
                    p_fear  = m_fear - m_fear / 4 + sum_f / 8;
                    p_doubt = m_doubt - m_doubt / 4 + sum_d / 8;
                    p_sat   = (p_fear > 255) || (p_doubt > 255);
                    if (p_fear > 255) p_fear = 255;
                    if (p_doubt > 255) p_doubt = 255;
                    sum_f = 0; sum_d = 0; n_smp = 0; due = 2;
                end
            end
            rdy_ok = 1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("fear",      fear,         m_fear);
            chk("doubt",     doubt,        m_doubt);
            chk("out_valid", out_valid,    m_pulse);
            chk("overflow",  overflow,     m_ovf);
            chk("win_count", window_count, m_wc);
            chk("s_ready",   s_ready,      (rdy_ok && due == 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic ch, input logic [7:0] d, output int stalls);
        bit took;
        s_valid = 1'b1;
        s_chan  = ch;
        s_data  = d;
        stalls  = 0;
        for (int i = 0; i < 12; i++) begin
            took = s_ready;
            tick();
            if (took) return;
            stalls++;
        end
        chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic window(input logic [7:0] d);
        int st;
        for (int i = 0; i < 8; i++) send(1'b0, d, st);
        s_valid = 1'b0;
    endtask

    initial begin
        int st;
        // 1: reset with s_valid high, then release
        s_valid = 1'b1; s_chan = 1'b0; s_data = 8'h55;
        tick(); tick();
        chk("rst_ready", s_ready, 0);
        chk("rst_fear", fear, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_wc", window_count, 0);
        reset = 1'b1;
        chk("rel_ready0", s_ready, 0);
        tick();
        chk("rel_ready1", s_ready, 1);
        s_valid = 1'b0;
        tick();

        // 2 and 3: two fear windows of 0x40
        window(8'h40);
        chk("t2_pulse_early", out_valid, 0);
        tick();
        chk("t2_pulse_n1", out_valid, 0);
        tick();
        chk("t2_pulse", out_valid, 1);
        chk("t2_fear", fear, 8'h40);
        chk("t2_doubt", doubt, 8'h00);
        chk("t2_wc", window_count, 1);
        window(8'h40);
        tick(); tick();
        chk("t3_fear", fear, 8'h70);
        chk("t3_wc", window_count, 2);
        chk("t3_ovf", overflow, 0);

        // 4: saturation and sticky overflow
        do_reset();
        window(8'hFF); tick(); tick();
        chk("t4_fear1", fear, 8'hFF);
        chk("t4_ovf1", overflow, 0);
        window(8'hFF); tick(); tick();
        chk("t4_fear2", fear, 8'hFF);
        chk("t4_ovf2", overflow, 1);
        window(8'h00); tick(); tick();
        chk("t4_fear3", fear, 8'd192);
        chk("t4_ovf3", overflow, 1);

        // 5: interleaved channels
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 8'h80, st);
            send(1'b1, 8'h20, st);
        end
        s_valid = 1'b0;
        tick(); tick();
        chk("t5_fear", fear, 8'h40);
        chk("t5_doubt", doubt, 8'h10);

        // 6: back-pressure during DECAY/EMIT, then reset mid-window
        do_reset();
        for (int i = 0; i < 8; i++) send(1'b0, 8'h10, st);
        chk("t6_ready_busy", s_ready, 0);
        send(1'b0, 8'h10, st);
        chk("t6_stalls", st, 2);
        for (int i = 0; i < 4; i++) send(1'b0, 8'h10, st);
        s_valid = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) send(1'b0, 8'h20, st);
        s_valid = 1'b0;
        tick(); tick();
        chk("t6_no_pulse", out_valid, 0);
        chk("t6_wc0", window_count, 0);
        for (int i = 0; i < 5; i++) send(1'b0, 8'h20, st);
        s_valid = 1'b0;
        tick(); tick();
        chk("t6_pulse", out_valid, 1);
        chk("t6_fear", fear, 8'h20);
        chk("t6_wc1", window_count, 1);

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                do_reset();
            end else if (r < 15) begin
                s_valid = 1'b0;
                tick();
            end else begin
                logic [7:0] d;
                d = ($urandom_range(0, 3) == 0) ? 8'(255 - $urandom_range(0, 15))
                                                : 8'($urandom_range(0, 255));
                send(1'($urandom_range(0, 1)), d, st);
                if ($urandom_range(0, 1) == 0) s_valid = 1'b0;
            end
        end
        s_valid = 1'b0;
        tick(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
